// File: rtl/trg_link_strt_seq_tmr_if.sv
// Bundle of the start-up sequencer's link-side signals.
//   master : the environment (MMCM/GTX side) driving lock, phase-change and sync
//            status, and observing the resets and status outputs.
//   slave  : the sequencer itself.
// Signals:
//   MMCM_LOCK     MMCM locked
//   CLK_PHS_CHNG  clock phase change in progress
//   SYNC_DONE     per-channel GTX TX sync complete
//   CH_MASK       1 = channel enabled (masked channels count as synced)
//   GTX_RST       GTX reset, active high
//   TRG_RST       trigger logic reset, active high
//   LINK_UP       high while running
//   SYNC_FAIL     high while latched in the failure state
//   RETRY_CNT     retries used since the last idle
//   TMR_ERR       one-cycle pulse on any replica disagreement
//   STATE         voted sequencer state, for debug
interface trg_link_strt_seq_tmr_if #(
    parameter int N_CH = 4,
    parameter int RCW  = 2
);
    logic            MMCM_LOCK;
    logic            CLK_PHS_CHNG;
    logic [N_CH-1:0] SYNC_DONE;
    logic [N_CH-1:0] CH_MASK;
    logic            GTX_RST;
    logic            TRG_RST;
    logic            LINK_UP;
    logic            SYNC_FAIL;
    logic [RCW-1:0]  RETRY_CNT;
    logic            TMR_ERR;
    logic [2:0]      STATE;

    modport master (
        output MMCM_LOCK, CLK_PHS_CHNG, SYNC_DONE, CH_MASK,
        input  GTX_RST, TRG_RST, LINK_UP, SYNC_FAIL, RETRY_CNT, TMR_ERR, STATE
    );

    modport slave (
        input  MMCM_LOCK, CLK_PHS_CHNG, SYNC_DONE, CH_MASK,
        output GTX_RST, TRG_RST, LINK_UP, SYNC_FAIL, RETRY_CNT, TMR_ERR, STATE
    );
endinterface

// File: rtl/trg_link_strt_seq_tmr.sv
// Triplicated start-up sequencer for the trigger clock domain and its GTX
// transmit links. Debounces MMCM lock, releases GTX reset, waits for TX sync
// on every enabled channel, retries with a GTX reset pulse on sync timeout and
// latches a failure after MAX_RETRY unsuccessful retries.
// Ports:
//   CLK  trigger-domain clock
//   RST  synchronous active-high reset
//   lnk  slave side of trg_link_strt_seq_tmr_if (lock/sync inputs, resets,
//        status, retry count, replica-disagreement pulse, voted state)
// State, counter, retry count and every registered output exist three times;
// everything leaving the block goes through a majority voter, and each
// replica computes its next value from the voted values so that a single
// upset replica is pulled back into line on the following edge.
module trg_link_strt_seq_tmr #(
    parameter int N_CH      = 4,
    parameter int LOCK_DLY  = 16,
    parameter int SYNC_TMO  = 1024,
    parameter int RST_HOLD  = 8,
    parameter int MAX_RETRY = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    trg_link_strt_seq_tmr_if.slave lnk
);
    localparam int CNT_MAX = (LOCK_DLY > SYNC_TMO)
                           ? ((LOCK_DLY > RST_HOLD) ? LOCK_DLY : RST_HOLD)
                           : ((SYNC_TMO > RST_HOLD) ? SYNC_TMO : RST_HOLD);
    localparam int CW  = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int RCW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CW-1:0]  LOCK_LAST = CW'(LOCK_DLY - 1);
    localparam logic [CW-1:0]  TMO_LAST  = CW'(SYNC_TMO - 1);
    localparam logic [CW-1:0]  HOLD_LAST = CW'(RST_HOLD - 1);
    localparam logic [RCW-1:0] RETRY_LIM = RCW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE      = 3'b000,
        S_LOCK_WAIT = 3'b001,
        S_W4SYNC    = 3'b010,
        S_RUN       = 3'b011,
        S_PHS_CHNG  = 3'b100,
        S_RETRY     = 3'b101,
        S_FAIL      = 3'b110
    } state_t;

    // Replica registers gathered for voting
    logic [2:0]     st_r   [3];
    logic [CW-1:0]  cnt_r  [3];
    logic [RCW-1:0] rc_r   [3];
    logic           gtx_r  [3];
    logic           trg_r  [3];
    logic           lnk_r  [3];
    logic           fail_r [3];
    logic           err_r  [3];

    logic [2:0]     st_v;
    logic [CW-1:0]  cnt_v;
    logic [RCW-1:0] rc_v;
    logic           all_sync;
    logic           mis;

    function automatic logic vote1(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    assign st_v  = (st_r[0]  & st_r[1])  | (st_r[0]  & st_r[2])  | (st_r[1]  & st_r[2]);
    assign cnt_v = (cnt_r[0] & cnt_r[1]) | (cnt_r[0] & cnt_r[2]) | (cnt_r[1] & cnt_r[2]);
    assign rc_v  = (rc_r[0]  & rc_r[1])  | (rc_r[0]  & rc_r[2])  | (rc_r[1]  & rc_r[2]);

    // Disabled channels are treated as already synced
    assign all_sync = &(lnk.SYNC_DONE | ~lnk.CH_MASK);

    always_comb begin
        mis = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if ((st_r[i] != st_v) || (cnt_r[i] != cnt_v) || (rc_r[i] != rc_v))
                mis = 1'b1;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_rep
        logic [2:0]     st_q;
        state_t         st_d;
        logic [CW-1:0]  cnt_q;
        logic [CW-1:0]  cnt_d;
        logic [RCW-1:0] rc_q;
        logic [RCW-1:0] rc_d;
        logic           gtx_q;
        logic           trg_q;
        logic           lnk_q;
        logic           fail_q;
        logic           err_q;

        // Next state: loss of lock first, then phase change, then sync/timeout
        always_comb begin
            st_d = S_IDLE;
            case (st_v)
                S_IDLE: begin
                    if (lnk.MMCM_LOCK) st_d = S_LOCK_WAIT;
                    else               st_d = S_IDLE;
                end
                S_LOCK_WAIT: begin
                    if (!lnk.MMCM_LOCK)          st_d = S_IDLE;
                    else if (cnt_v == LOCK_LAST) st_d = S_W4SYNC;
                    else                         st_d = S_LOCK_WAIT;
                end
                S_W4SYNC: begin
                    if (!lnk.MMCM_LOCK)         st_d = S_IDLE;
                    else if (lnk.CLK_PHS_CHNG)  st_d = S_PHS_CHNG;
                    else if (all_sync)          st_d = S_RUN;
                    else if (cnt_v == TMO_LAST) st_d = (rc_v < RETRY_LIM) ? S_RETRY : S_FAIL;
                    else                        st_d = S_W4SYNC;
                end
                S_RUN: begin
                    if (!lnk.MMCM_LOCK)        st_d = S_IDLE;
                    else if (lnk.CLK_PHS_CHNG) st_d = S_PHS_CHNG;
                    else if (!all_sync)        st_d = S_W4SYNC;
                    else                       st_d = S_RUN;
                end
                S_PHS_CHNG: begin
                    if (!lnk.CLK_PHS_CHNG) st_d = S_IDLE;
                    else                   st_d = S_PHS_CHNG;
                end
                S_RETRY: begin
                    if (!lnk.MMCM_LOCK)          st_d = S_IDLE;
                    else if (cnt_v == HOLD_LAST) st_d = S_W4SYNC;
                    else                         st_d = S_RETRY;
                end
                S_FAIL: begin
                    if (!lnk.MMCM_LOCK) st_d = S_IDLE;
                    else                st_d = S_FAIL;
                end
                default: st_d = S_IDLE;
            endcase
        end

        // Counter restarts only when a timed state is entered; retry count
        // is forced to zero whenever idle and bumps as a retry completes.
        always_comb begin
            cnt_d = cnt_v + CW'(1);
            if ((st_d != st_v) &&
                ((st_d == S_LOCK_WAIT) || (st_d == S_W4SYNC) || (st_d == S_RETRY)))
                cnt_d = '0;

            rc_d = rc_v;
            if (st_d == S_IDLE)
                rc_d = '0;
            else if ((st_v == S_RETRY) && (st_d == S_W4SYNC))
                rc_d = rc_v + RCW'(1);
        end

        always_ff @(posedge CLK) begin
            if (RST) begin
                st_q   <= S_IDLE;
                cnt_q  <= '0;
                rc_q   <= '0;
                gtx_q  <= 1'b1;
                trg_q  <= 1'b1;
                lnk_q  <= 1'b0;
                fail_q <= 1'b0;
                err_q  <= 1'b0;
            end else begin
                st_q   <= st_d;
                cnt_q  <= cnt_d;
                rc_q   <= rc_d;
                gtx_q  <= !((st_d == S_W4SYNC) || (st_d == S_RUN));
                trg_q  <= (st_d != S_RUN);
                lnk_q  <= (st_d == S_RUN);
                fail_q <= (st_d == S_FAIL);
                err_q  <= mis;
            end
        end

        assign st_r[g]   = st_q;
        assign cnt_r[g]  = cnt_q;
        assign rc_r[g]   = rc_q;
        assign gtx_r[g]  = gtx_q;
        assign trg_r[g]  = trg_q;
        assign lnk_r[g]  = lnk_q;
        assign fail_r[g] = fail_q;
        assign err_r[g]  = err_q;
    end

    assign lnk.STATE     = st_v;
    assign lnk.RETRY_CNT = rc_v;
    assign lnk.GTX_RST   = vote1(gtx_r[0],  gtx_r[1],  gtx_r[2]);
    assign lnk.TRG_RST   = vote1(trg_r[0],  trg_r[1],  trg_r[2]);
    assign lnk.LINK_UP   = vote1(lnk_r[0],  lnk_r[1],  lnk_r[2]);
    assign lnk.SYNC_FAIL = vote1(fail_r[0], fail_r[1], fail_r[2]);
    assign lnk.TMR_ERR   = vote1(err_r[0],  err_r[1],  err_r[2]);
endmodule

// File: tb/tb_trg_link_strt_seq_tmr.sv
// Bench for trg_link_strt_seq_tmr: directed start-up, retry, mask, phase-change,
// reset and replica-upset scenarios followed by randomized input traffic, all
// checked every cycle against a phase/elapsed-time reference model.
module tb_trg_link_strt_seq_tmr;
    localparam int N_CH      = 4;
    localparam int LOCK_DLY  = 16;
    localparam int SYNC_TMO  = 1024;
    localparam int RST_HOLD  = 8;
    localparam int MAX_RETRY = 3;
    localparam int RCW       = 2;

    localparam int P_IDLE = 0, P_LW = 1, P_W4 = 2, P_RUN = 3, P_PHS = 4, P_RTY = 5, P_FL = 6;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    trg_link_strt_seq_tmr_if #(.N_CH(N_CH), .RCW(RCW)) bus ();

    trg_link_strt_seq_tmr #(
        .N_CH(N_CH), .LOCK_DLY(LOCK_DLY), .SYNC_TMO(SYNC_TMO),
        .RST_HOLD(RST_HOLD), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .lnk(bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: current phase, cycles spent in that phase, retries used
    int m_ph   = P_IDLE;
    int m_t    = 0;
    int m_rc   = 0;
    bit m_tmr  = 0;
    bit m_vld  = 0;
    int inj_seq  = 0;
    int inj_seen = 0;

    always @(posedge CLK) begin : model
        logic as;
        logic lk;
        logic pc;
        int   nx;
        as = &(bus.SYNC_DONE | ~bus.CH_MASK);
        lk = bus.MMCM_LOCK;
        pc = bus.CLK_PHS_CHNG;
        if (RST) begin
            m_ph = P_IDLE; m_t = 0; m_rc = 0; m_tmr = 0; m_vld = 1;
        end else if (m_vld) begin
            nx = m_ph;
            case (m_ph)
                P_IDLE: if (lk) nx = P_LW;
                P_LW:   if (!lk) nx = P_IDLE; else if (m_t + 1 == LOCK_DLY) nx = P_W4;
                P_W4: begin
                    if (!lk)                     nx = P_IDLE;
                    else if (pc)                 nx = P_PHS;
                    else if (as)                 nx = P_RUN;
                    else if (m_t + 1 == SYNC_TMO) nx = (m_rc < MAX_RETRY) ? P_RTY : P_FL;
                end
                P_RUN:  if (!lk) nx = P_IDLE; else if (pc) nx = P_PHS; else if (!as) nx = P_W4;
                P_PHS:  if (!pc) nx = P_IDLE;
                P_RTY: begin
                    if (!lk) nx = P_IDLE;
                    else if (m_t + 1 == RST_HOLD) begin nx = P_W4; m_rc = m_rc + 1; end
                end
                P_FL:   if (!lk) nx = P_IDLE;
                default: nx = P_IDLE;
            endcase
            if (nx == P_IDLE) m_rc = 0;
            m_t   = (nx == m_ph) ? m_t + 1 : 0;
            m_ph  = nx;
            m_tmr = (inj_seq != inj_seen);
        end
        inj_seen = inj_seq;
    end

    always @(negedge CLK) begin : compare
        if (m_vld) begin
            chk("GTX_RST",   32'(bus.GTX_RST),   32'(!(m_ph == P_W4 || m_ph == P_RUN)));
            chk("TRG_RST",   32'(bus.TRG_RST),   32'(m_ph != P_RUN));
            chk("LINK_UP",   32'(bus.LINK_UP),   32'(m_ph == P_RUN));
            chk("SYNC_FAIL", 32'(bus.SYNC_FAIL), 32'(m_ph == P_FL));
            chk("STATE",     32'(bus.STATE),     32'(m_ph));
            chk("RETRY_CNT", 32'(bus.RETRY_CNT), 32'(m_rc));
            chk("TMR_ERR",   32'(bus.TMR_ERR),   32'(m_tmr));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_state(input int s, input int budget, input string nm);
        int n;
        n = 0;
        while (bus.STATE !== 3'(s) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk(nm, 32'(bus.STATE), 32'(s));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        int rty;
        logic phs_r;
        bus.MMCM_LOCK    = 1'b0;
        bus.CLK_PHS_CHNG = 1'b0;
        bus.SYNC_DONE    = '0;
        bus.CH_MASK      = '1;
        RST = 1'b1;
        tick(3);
        chk("rst_gtx",  32'(bus.GTX_RST),   32'd1);
        chk("rst_trg",  32'(bus.TRG_RST),   32'd1);
        chk("rst_link", 32'(bus.LINK_UP),   32'd0);
        chk("rst_st",   32'(bus.STATE),     32'd0);
        chk("rst_rc",   32'(bus.RETRY_CNT), 32'd0);
        chk("rst_tmr",  32'(bus.TMR_ERR),   32'd0);

        // Lock debounce, then sync
        RST = 1'b0;
        bus.MMCM_LOCK = 1'b1;
        tick(16);
        chk("dbnc16_gtx", 32'(bus.GTX_RST), 32'd1);
        tick(1);
        chk("dbnc17_gtx", 32'(bus.GTX_RST), 32'd0);
        chk("dbnc17_st",  32'(bus.STATE),   32'd2);
        bus.SYNC_DONE = 4'hF;
        tick(1);
        chk("run_st",   32'(bus.STATE),   32'h3);
        chk("run_trg",  32'(bus.TRG_RST), 32'd0);
        chk("run_link", 32'(bus.LINK_UP), 32'd1);

        // Replica 2 upset while running
        tick(2);
        force dut.g_rep[2].st_q = 3'b110;
        inj_seq++;
        #1;
        release dut.g_rep[2].st_q;
        tick(1);
        chk("upset_tmr",  32'(bus.TMR_ERR), 32'd1);
        chk("upset_st",   32'(bus.STATE),   32'd3);
        chk("upset_link", 32'(bus.LINK_UP), 32'd1);
        tick(1);
        chk("upset_tmr_clr", 32'(bus.TMR_ERR), 32'd0);

        // Phase change: lock is ignored meanwhile
        bus.CLK_PHS_CHNG = 1'b1;
        tick(1);
        chk("phs_st",  32'(bus.STATE),   32'd4);
        chk("phs_gtx", 32'(bus.GTX_RST), 32'd1);
        bus.MMCM_LOCK = 1'b0;
        tick(1);
        chk("phs_nolock_st", 32'(bus.STATE), 32'd4);
        bus.MMCM_LOCK = 1'b1;
        bus.CLK_PHS_CHNG = 1'b0;
        tick(1);
        chk("phs_end_st", 32'(bus.STATE), 32'd0);

        // Lock glitch mid-debounce restarts the full interval
        bus.SYNC_DONE = '0;
        tick(10);
        bus.MMCM_LOCK = 1'b0;
        tick(1);
        chk("glitch_st",  32'(bus.STATE),   32'd0);
        chk("glitch_gtx", 32'(bus.GTX_RST), 32'd1);
        bus.MMCM_LOCK = 1'b1;
        tick(16);
        chk("relock16_gtx", 32'(bus.GTX_RST), 32'd1);
        tick(1);
        chk("relock17_gtx", 32'(bus.GTX_RST), 32'd0);

        // No sync: three retries, then FAIL
        n = 0; rty = 0;
        while (bus.STATE !== 3'd6 && n < 6000) begin
            @(negedge CLK);
            n++;
            if (bus.STATE === 3'd5) rty++;
        end
        chk("fail_reached", 32'(bus.STATE), 32'd6);
        chk("retry_cycles", 32'(rty), 32'd24);
        chk("fail_rc",   32'(bus.RETRY_CNT), 32'd3);
        chk("fail_flag", 32'(bus.SYNC_FAIL), 32'd1);
        tick(5);
        chk("fail_sticky", 32'(bus.STATE), 32'd6);
        bus.MMCM_LOCK = 1'b0;
        tick(1);
        chk("fail_exit_st",   32'(bus.STATE),     32'd0);
        chk("fail_exit_flag", 32'(bus.SYNC_FAIL), 32'd0);
        chk("fail_exit_rc",   32'(bus.RETRY_CNT), 32'd0);

        // Masked channels, sync loss, sync exactly at timeout
        bus.CH_MASK   = 4'b0101;
        bus.SYNC_DONE = 4'b0101;
        bus.MMCM_LOCK = 1'b1;
        wait_state(P_RUN, 40, "mask_run");
        bus.SYNC_DONE = 4'b0100;
        tick(1);
        chk("loss_st",   32'(bus.STATE),   32'd2);
        chk("loss_trg",  32'(bus.TRG_RST), 32'd1);
        chk("loss_gtx",  32'(bus.GTX_RST), 32'd0);
        tick(SYNC_TMO - 1);
        bus.SYNC_DONE = 4'b0101;
        tick(1);
        chk("tmo_sync_st", 32'(bus.STATE), 32'd3);
        bus.CH_MASK   = '0;
        bus.SYNC_DONE = '0;
        tick(1);
        chk("nomask_st", 32'(bus.STATE), 32'd3);

        // Reset while waiting for sync
        bus.CH_MASK = '1;
        tick(1);
        chk("w4_st", 32'(bus.STATE), 32'd2);
        RST = 1'b1;
        tick(1);
        chk("rstw4_st",  32'(bus.STATE),   32'd0);
        chk("rstw4_gtx", 32'(bus.GTX_RST), 32'd1);
        chk("rstw4_trg", 32'(bus.TRG_RST), 32'd1);
        RST = 1'b0;

        // Randomized traffic
        phs_r = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge CLK);
            bus.MMCM_LOCK = ($urandom_range(0, 63) != 0);
            if ($urandom_range(0, 39) == 0) phs_r = ~phs_r;
            bus.CLK_PHS_CHNG = phs_r;
            if ($urandom_range(0, 7) == 0) bus.SYNC_DONE = 4'($urandom);
            if ($urandom_range(0, 99) == 0) bus.CH_MASK = 4'($urandom);
            RST = ($urandom_range(0, 499) == 0);
        end
        RST = 1'b0;
        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
